// File: rtl/pcie_pkg.sv
// pcie_pkg: shared TLP header layout, FSM states and memory-request header builders.
package pcie_pkg;
  localparam int MAX_PAYLOAD_SIZE  = 128;
  localparam int MAX_READ_REQ_SIZE = 512;

  typedef enum logic [1:0] {IDLE, CALC, EMIT} state_t;

  // 4DW memory request header, first transmitted bit at the MSB
  typedef struct packed {
    logic [2:0]  fmt;
    logic [4:0]  tlp_type;
    logic        t9;
    logic [2:0]  tc;
    logic        t8;
    logic        attr2;
    logic        ln;
    logic        th;
    logic        td;
    logic        ep;
    logic [1:0]  attr;
    logic [1:0]  at;
    logic [1:0]  length_h;
    logic [7:0]  length_l;
    logic [15:0] requester_id;
    logic [7:0]  tag;
    logic [3:0]  last_dbe;
    logic [3:0]  first_dbe;
    logic [61:0] addr;
    logic [1:0]  ph;
  } tlp_memory_req_hdr_t;

  function automatic tlp_memory_req_hdr_t gen_tlp_memrd_hdr(
    input logic [15:0] req_id, input logic [9:0] tag, input logic [61:0] dw_addr,
    input logic [9:0] len, input logic [3:0] first_dbe, input logic [3:0] last_dbe);
    tlp_memory_req_hdr_t h;
    h = '0;
    h.fmt          = 3'b001;
    h.t9           = tag[9];
    h.t8           = tag[8];
    h.length_h     = len[9:8];
    h.length_l     = len[7:0];
    h.requester_id = req_id;
    h.tag          = tag[7:0];
    h.last_dbe     = last_dbe;
    h.first_dbe    = first_dbe;
    h.addr         = dw_addr;
    return h;
  endfunction

  function automatic tlp_memory_req_hdr_t gen_tlp_memwr_hdr(
    input logic [15:0] req_id, input logic [61:0] dw_addr,
    input logic [9:0] len, input logic [3:0] first_dbe, input logic [3:0] last_dbe);
    tlp_memory_req_hdr_t h;
    h = gen_tlp_memrd_hdr(req_id, 10'd0, dw_addr, len, first_dbe, last_dbe);
    h.fmt = 3'b011;
    return h;
  endfunction
endpackage

// File: rtl/pcie_tag_pool.sv
// pcie_tag_pool: read-tag bitmap with lowest-free-index allocation and release.
module pcie_tag_pool #(
  parameter int TAG_COUNT = 32
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        alloc_i,
  input  logic        rel_valid_i,
  input  logic [9:0]  rel_tag_i,
  output logic        avail_o,
  output logic [9:0]  tag_o,
  output logic [10:0] used_o
);
  logic [TAG_COUNT-1:0] used_q, used_d;
  logic [10:0] cnt_q;
  logic rel_hit;

  // Encoder looks at the pre-release bitmap, so a same-cycle release is not yet visible
  always_comb begin
    avail_o = 1'b0;
    tag_o   = '0;
    rel_hit = 1'b0;
    used_d  = used_q;
    for (int i = TAG_COUNT - 1; i >= 0; i--) begin
      if (!used_q[i]) begin
        avail_o = 1'b1;
        tag_o   = 10'(i);
      end
    end
    for (int i = 0; i < TAG_COUNT; i++) begin
      if (rel_valid_i && rel_tag_i == 10'(i) && used_q[i]) begin
        used_d[i] = 1'b0;
        rel_hit   = 1'b1;
      end
      if (alloc_i && tag_o == 10'(i)) used_d[i] = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      used_q <= '0;
      cnt_q  <= '0;
    end else begin
      used_q <= used_d;
      cnt_q  <= cnt_q + 11'(alloc_i) - 11'(rel_hit);
    end
  end

  assign used_o = cnt_q;
endmodule

// File: rtl/pcie_tlp_req_gen.sv
// pcie_tlp_req_gen: splits memory read/write requests into boundary-safe MRd/MWr TLP headers.
module pcie_tlp_req_gen import pcie_pkg::*; #(
  parameter int MAX_PAYLOAD = MAX_PAYLOAD_SIZE,
  parameter int MAX_RD_REQ  = MAX_READ_REQ_SIZE,
  parameter int TAG_COUNT   = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         req_valid,
  output logic         req_ready,
  input  logic         req_wr,
  input  logic [63:0]  req_addr,
  input  logic [12:0]  req_len,
  input  logic [15:0]  requester_id,
  output logic         tlp_valid,
  input  logic         tlp_ready,
  output logic [127:0] tlp_hdr,
  output logic         tlp_wr,
  output logic [12:0]  tlp_byte_cnt,
  output logic         tlp_last,
  input  logic         tag_rel_valid,
  input  logic [9:0]   tag_rel_tag,
  output logic         busy,
  output logic [10:0]  tags_used
);
  localparam logic [12:0] MAX_WR = 13'(MAX_PAYLOAD);
  localparam logic [12:0] MAX_RD = 13'(MAX_RD_REQ);

  state_t state_q;
  logic [63:0] addr_q;
  logic [12:0] rem_q, tlp_byte_cnt_q;
  logic wr_q, req_ready_q, tlp_valid_q, tlp_wr_q, tlp_last_q;
  tlp_memory_req_hdr_t tlp_hdr_q;

  logic [12:0] max_sz, room, chunk;
  logic [9:0] dw_len, tag;
  logic [1:0] end_lo;
  logic [3:0] first_m, last_m, fbe, lbe;
  logic single, tag_avail, can_go;

  // Room to the next MAX-aligned boundary also bounds at 4 KB since MAX <= 4096
  assign max_sz  = wr_q ? MAX_WR : MAX_RD;
  assign room    = max_sz - (addr_q[12:0] & (max_sz - 13'd1));
  assign chunk   = rem_q < room ? rem_q : room;
  assign dw_len  = 10'((14'(addr_q[1:0]) + 14'(chunk) + 14'd3) >> 2);
  assign end_lo  = addr_q[1:0] + chunk[1:0] - 2'd1;
  assign first_m = 4'hF << addr_q[1:0];
  assign last_m  = 4'hF >> (2'd3 - end_lo);
  assign single  = dw_len == 10'd1;
  assign fbe     = single ? (first_m & last_m) : first_m;
  assign lbe     = single ? 4'h0 : last_m;
  assign can_go  = wr_q || tag_avail;

  pcie_tag_pool #(.TAG_COUNT(TAG_COUNT)) u_pool (
    .clk         (clk),
    .rst_n       (rst_n),
    .alloc_i     (state_q == CALC && !wr_q && tag_avail),
    .rel_valid_i (tag_rel_valid),
    .rel_tag_i   (tag_rel_tag),
    .avail_o     (tag_avail),
    .tag_o       (tag),
    .used_o      (tags_used)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= IDLE;
      addr_q         <= '0;
      rem_q          <= '0;
      wr_q           <= 1'b0;
      req_ready_q    <= 1'b0;
      tlp_valid_q    <= 1'b0;
      tlp_hdr_q      <= '0;
      tlp_byte_cnt_q <= '0;
      tlp_last_q     <= 1'b0;
      tlp_wr_q       <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          req_ready_q <= 1'b1;
          if (req_valid && req_ready_q) begin
            addr_q <= req_addr;
            rem_q  <= req_len;
            wr_q   <= req_wr;
            if (req_len != 13'd0) begin
              state_q     <= CALC;
              req_ready_q <= 1'b0;
            end
          end
        end
        CALC: if (can_go) begin
          tlp_hdr_q      <= wr_q ? gen_tlp_memwr_hdr(requester_id, addr_q[63:2], dw_len, fbe, lbe)
                                 : gen_tlp_memrd_hdr(requester_id, tag, addr_q[63:2], dw_len, fbe, lbe);
          tlp_byte_cnt_q <= chunk;
          tlp_last_q     <= chunk == rem_q;
          tlp_wr_q       <= wr_q;
          tlp_valid_q    <= 1'b1;
          state_q        <= EMIT;
        end
        EMIT: if (tlp_ready) begin
          tlp_valid_q <= 1'b0;
          addr_q      <= addr_q + 64'(tlp_byte_cnt_q);
          rem_q       <= rem_q - tlp_byte_cnt_q;
          state_q     <= tlp_last_q ? IDLE : CALC;
          req_ready_q <= tlp_last_q;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign req_ready    = req_ready_q;
  assign tlp_valid    = tlp_valid_q;
  assign tlp_hdr      = tlp_hdr_q;
  assign tlp_wr       = tlp_wr_q;
  assign tlp_byte_cnt = tlp_byte_cnt_q;
  assign tlp_last     = tlp_last_q;
  assign busy         = state_q != IDLE;
endmodule
